bcd_alarm_clock: RTL and testbench
==================================

BCD_ALARM_CLOCK -- requirements
Module: bcd_alarm_clock

Interface
REQ-001 Parameter FREQ_W, default 32: width of clock_frequency and of the prescaler counter.
REQ-002 Parameter ALARM_LEN, default 60: number of one_sec_pulse ticks the alarm output stays asserted.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 clock_frequency  in  FREQ_W  clk cycles per second; value 0 SHALL be treated as 1.
REQ-006 load  in  1  single-cycle request to load set_time.
REQ-007 set_time  in  24  BCD hh:mm:ss, 24h format, [23:20]=hour tens ... [3:0]=sec ones.
REQ-008 alarm_en  in  1  level; arms alarm, deassertion silences it.
REQ-009 alarm_time  in  16  BCD hh:mm, 24h format.
REQ-010 mode_12h  in  1  level; selects 12h display format.
REQ-011 hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones  out  4 each  displayed BCD time.
REQ-012 pm  out  1  high for 12:00:00-23:59:59 in 12h mode; always 0 in 24h mode.
REQ-013 one_sec_pulse  out  1  one-cycle tick at each second boundary.
REQ-014 alarm  out  1  alarm ringing.
REQ-015 load_err  out  1  one-cycle pulse: rejected load.

Function
REQ-016 Prescaler counts 0..N-1 (N = effective clock_frequency); at count >= N-1 it SHALL wrap to 0 and assert one_sec_pulse for exactly that cycle.
REQ-017 A change of clock_frequency takes effect immediately; a count already >= new N-1 SHALL fire on the next cycle.
REQ-018 Internal time is 24h BCD; on each tick sec increments, 59->00 carries into min, 59->00 carries into hour, 23:59:59 wraps to 00:00:00 in the same tick.
REQ-019 Time registers update on the clk edge after the cycle in which one_sec_pulse is high.
REQ-020 load with valid set_time (every digit <= 9, sec/min tens <= 5, hour <= 23) SHALL load time and clear the prescaler to 0 on the same edge.
REQ-021 load has priority over a coincident tick; that tick is discarded and one_sec_pulse SHALL be 0 in that cycle.
REQ-022 Invalid set_time SHALL leave time and prescaler unchanged and pulse load_err for one cycle.
REQ-023 Display: 24h mode passes internal time through; 12h mode maps hour 00->12 (pm=0), 01-11 unchanged (pm=0), 12 unchanged (pm=1), 13-23 -> minus 12 (pm=1); minutes and seconds are never altered.
REQ-024 Display outputs are combinational from internal registers; mode_12h changes are reflected in the same cycle.
REQ-025 Alarm FSM states: IDLE, RINGING.
REQ-026 IDLE->RINGING when alarm_en=1 and a tick or load makes time equal alarm_time:00; ring counter is cleared.
REQ-027 RINGING counts ticks; it returns to IDLE after ALARM_LEN ticks, or on the edge after alarm_en samples 0.
REQ-028 alarm = 1 exactly while in RINGING.
REQ-029 An invalid alarm_time SHALL never match.

Reset
REQ-030 Reset SHALL clear time to 00:00:00, the prescaler to 0, the alarm FSM to IDLE and the ring counter to 0; one_sec_pulse, load_err and alarm read 0 in the following cycle.
REQ-031 Reset SHALL override load and tick in the same cycle.
REQ-032 After reset, 12h mode displays 12:00:00 with pm=0.

Structure
REQ-033 Shared package clock_pkg holds: BCD digit typedef, BCD time struct, constants for digit limits (9, 5, 23), and the alarm state enum.
REQ-034 One sub-module, bcd_mod_counter: a parametrised single-digit BCD counter with modulus, increment, carry-out and synchronous load; it is instantiated per digit, with the hour pair wrap handled in the top.

Verification
REQ-035 clock_frequency=4, reset released -> one_sec_pulse every 4th cycle; sec_ones 0->1 on the edge after the first pulse.
REQ-036 load 23:59:59, one tick -> 00:00:00; in 12h mode display is 12:00:00 with pm=0.
REQ-037 load 13:05:00, mode_12h=1 -> display 01:05:00 with pm=1; mode_12h=0 -> 13:05:00 with pm=0.
REQ-038 load 24:00:00 or 12:60:00 -> load_err high for 1 cycle; time unchanged.
REQ-039 ALARM_LEN=3, alarm_time 07:30, load 07:29:59, one tick -> alarm=1 for 3 ticks; repeat with alarm_en dropped after 1 tick -> alarm=0 on the next edge.
REQ-040 Reset asserted mid-count at 10:10:10 while RINGING -> next cycle time 00:00:00, alarm=0, and the first pulse arrives N cycles after reset release.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and helpers for the BCD alarm clock.
//   bcd_t          : one BCD digit
//   bcd_time_t     : hh:mm:ss as six BCD digits, hour tens in the MSBs
//   alarm_state_t  : alarm FSM states
//   time_valid()   : true when a BCD time is a legal 24h time
package clock_pkg;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t hr_t;
        bcd_t hr_o;
        bcd_t mn_t;
        bcd_t mn_o;
        bcd_t sc_t;
        bcd_t sc_o;
    } bcd_time_t;

    localparam bcd_t DIGIT_MAX = 4'd9;
    localparam bcd_t TENS_MAX  = 4'd5;
    localparam int   HOUR_MAX  = 23;

    typedef enum logic {
        ALM_IDLE,
        ALM_RINGING
    } alarm_state_t;

    function automatic logic time_valid(bcd_time_t t);
        int hr;
        hr = 10 * int'(t.hr_t) + int'(t.hr_o);
        return (t.hr_o <= DIGIT_MAX) && (t.mn_o <= DIGIT_MAX) &&
               (t.sc_o <= DIGIT_MAX) && (t.mn_t <= TENS_MAX)  &&
               (t.sc_t <= TENS_MAX)  && (hr <= HOUR_MAX);
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Single BCD digit counter with programmable modulus.
//   clk, reset : clock, synchronous active-high reset (clears to 0)
//   inc        : advance by one; wraps MOD-1 -> 0
//   load       : synchronous load of load_val (wins over inc)
//   q          : current digit
//   nxt        : value q takes on the next edge (lets the parent look ahead)
//   carry      : inc while at MOD-1, i.e. this digit is wrapping
module bcd_mod_counter #(
    parameter int MOD = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] q,
    output logic [3:0] nxt,
    output logic       carry
);
    localparam logic [3:0] LAST = 4'(MOD - 1);

    assign carry = inc && (q == LAST);

    always_comb begin
        nxt = q;
        if (load)
            nxt = load_val;
        else if (carry)
            nxt = 4'd0;
        else if (inc)
            nxt = q + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            q <= 4'd0;
        else
            q <= nxt;
    end

endmodule

// File: rtl/bcd_alarm_clock.sv
// BCD time-of-day clock with prescaler, load, 12h display and alarm.
//   clk, reset         : clock, synchronous active-high reset
//   clock_frequency    : clk cycles per second (0 behaves as 1)
//   load / set_time    : one-cycle request to load BCD hh:mm:ss
//   alarm_en           : arms the alarm; dropping it silences ringing
//   alarm_time         : BCD hh:mm alarm point (fires at hh:mm:00)
//   mode_12h           : selects 12h display
//   hour_tens..sec_ones: displayed BCD time, pm flag
//   one_sec_pulse      : one-cycle tick at each second boundary
//   alarm              : high while ringing
//   load_err           : one-cycle pulse after an illegal set_time
module bcd_alarm_clock #(
    parameter int FREQ_W    = 32,
    parameter int ALARM_LEN = 60
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FREQ_W-1:0] clock_frequency,
    input  logic              load,
    input  logic [23:0]       set_time,
    input  logic              alarm_en,
    input  logic [15:0]       alarm_time,
    input  logic              mode_12h,
    output logic [3:0]        hour_tens,
    output logic [3:0]        hour_ones,
    output logic [3:0]        min_tens,
    output logic [3:0]        min_ones,
    output logic [3:0]        sec_tens,
    output logic [3:0]        sec_ones,
    output logic              pm,
    output logic              one_sec_pulse,
    output logic              alarm,
    output logic              load_err
);
    import clock_pkg::*;

    localparam int RING_W = $clog2(ALARM_LEN + 1);

    // ---------------- prescaler ----------------
    logic [FREQ_W-1:0] presc_q, n_eff;
    logic              set_ok, load_ok, presc_hit, tick;

    assign n_eff     = (clock_frequency == '0) ? FREQ_W'(1) : clock_frequency;
    assign set_ok    = time_valid(bcd_time_t'(set_time));
    assign load_ok   = load && set_ok;
    // >= rather than == so a lowered frequency fires at once
    assign presc_hit = presc_q >= (n_eff - FREQ_W'(1));
    assign tick      = presc_hit && !load_ok && !reset;

    assign one_sec_pulse = tick;

    always_ff @(posedge clk) begin
        if (reset)
            presc_q <= '0;
        else if (load_ok || presc_hit)
            presc_q <= '0;
        else
            presc_q <= presc_q + FREQ_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            load_err <= 1'b0;
        else
            load_err <= load && !set_ok;
    end

    // ---------------- time digits ----------------
    logic [3:0] q_so, q_st, q_mo, q_mt, q_ho, q_ht;
    logic [3:0] n_so, n_st, n_mo, n_mt, n_ho, n_ht;
    logic       c_so, c_st, c_mo, c_mt, c_ho, c_ht;
    logic       hour_wrap, hour_ld;

    // 23:59:59 -> 00:00:00 is done by loading zeros into the hour pair.
    // A tens-of-hours rollover cannot occur from legal times, but if it
    // ever did, clearing the pair keeps the hour legal.
    assign hour_wrap = (c_mt && q_ht == 4'd2 && q_ho == 4'd3) || c_ht;
    assign hour_ld   = load_ok || hour_wrap;

    bcd_mod_counter #(.MOD(10)) u_sec_ones (.clk(clk), .reset(reset), .inc(tick),
        .load(load_ok), .load_val(set_time[3:0]), .q(q_so), .nxt(n_so), .carry(c_so));
    bcd_mod_counter #(.MOD(6))  u_sec_tens (.clk(clk), .reset(reset), .inc(c_so),
        .load(load_ok), .load_val(set_time[7:4]), .q(q_st), .nxt(n_st), .carry(c_st));
    bcd_mod_counter #(.MOD(10)) u_min_ones (.clk(clk), .reset(reset), .inc(c_st),
        .load(load_ok), .load_val(set_time[11:8]), .q(q_mo), .nxt(n_mo), .carry(c_mo));
    bcd_mod_counter #(.MOD(6))  u_min_tens (.clk(clk), .reset(reset), .inc(c_mo),
        .load(load_ok), .load_val(set_time[15:12]), .q(q_mt), .nxt(n_mt), .carry(c_mt));
    bcd_mod_counter #(.MOD(10)) u_hr_ones  (.clk(clk), .reset(reset), .inc(c_mt),
        .load(hour_ld), .load_val(load_ok ? set_time[19:16] : 4'd0),
        .q(q_ho), .nxt(n_ho), .carry(c_ho));
    bcd_mod_counter #(.MOD(3))  u_hr_tens  (.clk(clk), .reset(reset), .inc(c_ho),
        .load(hour_ld), .load_val(load_ok ? set_time[23:20] : 4'd0),
        .q(q_ht), .nxt(n_ht), .carry(c_ht));

    // ---------------- alarm ----------------
    bcd_time_t    nxt_t, alm_t;
    logic         alarm_hit;
    alarm_state_t st_q, st_d;
    logic [RING_W-1:0] ring_q, ring_d;

    assign nxt_t = {n_ht, n_ho, n_mt, n_mo, n_st, n_so};
    assign alm_t = {alarm_time, 8'h00};
    // compare against the time about to be written so ringing starts on
    // the same edge the matching time appears
    assign alarm_hit = alarm_en && (tick || load_ok) && time_valid(alm_t) &&
                       (nxt_t == alm_t);

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q   <= ALM_IDLE;
            ring_q <= '0;
        end else begin
            st_q   <= st_d;
            ring_q <= ring_d;
        end
    end

    always_comb begin
        st_d   = st_q;
        ring_d = ring_q;
        case (st_q)
            ALM_IDLE: begin
                if (alarm_hit) begin
                    st_d   = ALM_RINGING;
                    ring_d = '0;
                end
            end
            ALM_RINGING: begin
                if (!alarm_en) begin
                    st_d = ALM_IDLE;
                end else if (tick) begin
                    ring_d = ring_q + RING_W'(1);
                    if (ring_q == RING_W'(ALARM_LEN - 1))
                        st_d = ALM_IDLE;
                end
            end
            default: st_d = ALM_IDLE;
        endcase
    end

    assign alarm = (st_q == ALM_RINGING);

    // ---------------- display ----------------
    logic [4:0] hr24, hr12;

    assign hr24 = 5'(q_ht) * 5'd10 + 5'(q_ho);

    always_comb begin
        hr12 = hr24;
        if (hr24 == 5'd0)
            hr12 = 5'd12;
        else if (hr24 > 5'd12)
            hr12 = hr24 - 5'd12;
    end

    always_comb begin
        hour_tens = q_ht;
        hour_ones = q_ho;
        pm        = 1'b0;
        if (mode_12h) begin
            pm = (hr24 >= 5'd12);
            if (hr12 >= 5'd10) begin
                hour_tens = 4'd1;
                hour_ones = 4'(hr12 - 5'd10);
            end else begin
                hour_tens = 4'd0;
                hour_ones = hr12[3:0];
            end
        end
    end

    assign min_tens = q_mt;
    assign min_ones = q_mo;
    assign sec_tens = q_st;
    assign sec_ones = q_so;

endmodule

// File: tb/tb_bcd_alarm_clock.sv
// Randomized scoreboard bench for bcd_alarm_clock. The reference model keeps
// time as seconds-of-day and the prescaler as a plain integer.
module tb_bcd_alarm_clock;

    localparam int FW = 32;
    localparam int AL = 3;

    logic          clk = 1'b0;
    logic          reset, load, alarm_en, mode_12h;
    logic [FW-1:0] clock_frequency;
    logic [23:0]   set_time;
    logic [15:0]   alarm_time;
    logic [3:0]    hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones;
    logic          pm, one_sec_pulse, alarm, load_err;

    always #5 clk = ~clk;

    bcd_alarm_clock #(.FREQ_W(FW), .ALARM_LEN(AL)) dut (
        .clk(clk), .reset(reset), .clock_frequency(clock_frequency),
        .load(load), .set_time(set_time), .alarm_en(alarm_en),
        .alarm_time(alarm_time), .mode_12h(mode_12h),
        .hour_tens(hour_tens), .hour_ones(hour_ones), .min_tens(min_tens),
        .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .pm(pm), .one_sec_pulse(one_sec_pulse), .alarm(alarm), .load_err(load_err)
    );

    typedef struct {
        logic [23:0] disp;
        logic        pm, pulse, alarm, err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    bit   started = 0;

    // reference state
    int m_secs = 0, m_cnt = 0, m_rung = 0;
    bit m_ring = 0, m_err = 0;

    function automatic bit hms_ok(logic [23:0] t);
        int ht, ho, mt, mo, st, so;
        ht = int'(t[23:20]); ho = int'(t[19:16]); mt = int'(t[15:12]);
        mo = int'(t[11:8]);  st = int'(t[7:4]);   so = int'(t[3:0]);
        return (ht * 10 + ho <= 23) && ho <= 9 && mt <= 5 && mo <= 9 && st <= 5 && so <= 9;
    endfunction

    function automatic int hms_secs(logic [23:0] t);
        return (int'(t[23:20]) * 10 + int'(t[19:16])) * 3600 +
               (int'(t[15:12]) * 10 + int'(t[11:8])) * 60 +
               int'(t[7:4]) * 10 + int'(t[3:0]);
    endfunction

    function automatic logic [23:0] enc(int s);
        int h, m, c;
        h = s / 3600; m = (s / 60) % 60; c = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    function automatic logic [23:0] disp_of(int s, bit m12);
        int h;
        h = s / 3600;
        if (m12) begin
            h = h % 12;
            if (h == 0) h = 12;
        end
        return enc(h * 3600 + s % 3600);
    endfunction

    // one clock cycle: predict this cycle's outputs, advance the model
    task automatic step();
        exp_t e;
        int   n, nsecs, asecs;
        bit   ok, ld_ok, tk;
        logic [23:0] at;
        n     = (clock_frequency == 0) ? 1 : int'(clock_frequency);
        ok    = hms_ok(set_time);
        ld_ok = load && ok;
        tk    = !reset && !ld_ok && (m_cnt >= n - 1);
        e.disp  = disp_of(m_secs, mode_12h);
        e.pm    = mode_12h && (m_secs >= 12 * 3600);
        e.pulse = tk;
        e.alarm = m_ring;
        e.err   = m_err;
        q.push_back(e);
        started = 1;
        if (reset) begin
            m_secs = 0; m_cnt = 0; m_ring = 0; m_rung = 0; m_err = 0;
        end else begin
            m_err = load && !ok;
            nsecs = ld_ok ? hms_secs(set_time) : (tk ? (m_secs + 1) % 86400 : m_secs);
            m_cnt = (ld_ok || m_cnt >= n - 1) ? 0 : m_cnt + 1;
            at    = {alarm_time, 8'h00};
            asecs = hms_secs(at);
            if (m_ring) begin
                if (!alarm_en) m_ring = 0;
                else if (tk) begin
                    m_rung++;
                    if (m_rung == AL) m_ring = 0;
                end
            end else if (alarm_en && (tk || ld_ok) && hms_ok(at) && nsecs == asecs) begin
                m_ring = 1;
                m_rung = 0;
            end
            m_secs = nsecs;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic do_load(logic [23:0] t);
        load = 1; set_time = t;
        step();
        load = 0;
    endtask

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // monitor: every cycle the DUT presents outputs, compare to the queue head
    initial begin : monitor
        exp_t e;
        wait (started);
        forever begin
            @(negedge clk);
            if (q.size() == 0) begin
                checks++; failures++;
                $display("FAIL sb_empty: got 0 entries expected 1");
            end else begin
                e = q.pop_front();
                check("display", {hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones}, e.disp);
                check("pm", pm, e.pm);
                check("one_sec_pulse", one_sec_pulse, e.pulse);
                check("alarm", alarm, e.alarm);
                check("load_err", load_err, e.err);
            end
        end
    end

    initial begin : driver
        int r, a, lt;
        logic [23:0] t;
        reset = 1; load = 0; set_time = '0; alarm_en = 0; alarm_time = '0;
        mode_12h = 0; clock_frequency = 4;
        @(posedge clk);
        #1;
        run(2);
        reset = 0;
        mode_12h = 1; step(); mode_12h = 0;     // 12:00:00 am after reset
        run(12);                                 // pulse every 4th cycle

        do_load(24'h235959); run(4);             // midnight wrap
        mode_12h = 1; run(2); mode_12h = 0;

        do_load(24'h130500);                     // 12h mapping
        mode_12h = 1; run(2); mode_12h = 0; run(2);

        do_load(24'h240000); run(2);             // illegal loads
        do_load(24'h126000); run(2);

        alarm_en = 1; alarm_time = 16'h0730;     // alarm rings AL ticks
        do_load(24'h072959); run(20);
        do_load(24'h072959); run(5);             // drop enable mid-ring
        alarm_en = 0; run(3); alarm_en = 1;

        alarm_time = 16'h1010;                   // reset while ringing
        do_load(24'h101000); run(2);
        reset = 1; step(); reset = 0;
        run(10);

        clock_frequency = 8; run(5);             // frequency changes
        clock_frequency = 2; run(3);
        clock_frequency = 0; run(4);
        clock_frequency = 1; run(2);
        do_load(24'h095959); run(3);             // load beats coincident tick
        alarm_time = 16'h9930;                   // illegal alarm never matches
        do_load(24'h093000); run(3);

        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 4) begin
                clock_frequency = $urandom_range(0, 6); step();
            end else if (r < 8) begin
                do_load(enc($urandom_range(0, 86399)));
            end else if (r < 10) begin
                do_load(24'($urandom));
            end else if (r < 13) begin
                a  = $urandom_range(0, 23) * 3600 + $urandom_range(0, 59) * 60;
                t  = enc(a);
                alarm_time = t[23:8];
                alarm_en = 1;
                lt = (a + 86399) % 86400;
                do_load(enc(lt));
            end else if (r < 15) begin
                alarm_en = ($urandom_range(0, 3) != 0); step();
            end else if (r < 18) begin
                mode_12h = ~mode_12h; step();
            end else if (r == 18) begin
                reset = 1; step(); reset = 0;
            end else begin
                step();
            end
        end

        if (q.size() != 0) begin
            checks++; failures++;
            $display("FAIL sb_leftover: got %0d entries expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
